ready_io_sequencer: RTL and testbench

//  Sequences the operator I/O for the picoMIPS affine-transform datapath.
//  - Captures operands x, y from sw[] on successive `ready` rising edges.
//  - Launches one datapath computation, then shows x2 and y2 on LED[] in turn, each step paced by `ready`.
//  - Sits between board switches/LEDs and the compute core; owns all handshake sequencing.

---
 rtl/ready_io_sequencer_pkg.sv | 5 +
 rtl/ready_io_sequencer_if.sv | 7 +
 rtl/ready_io_sequencer_ready_conditioner.sv | 40 ++++
 rtl/ready_io_sequencer.sv | 62 ++++++
 tb/tb_ready_io_sequencer.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/ready_io_sequencer_pkg.sv
// io_seq_pkg: shared state encoding and default width for ready_io_sequencer
package io_seq_pkg;
  typedef enum logic [2:0] {GET_X, REL_X, GET_Y, REL_Y, COMPUTE, SHOW_X2, SHOW_Y2} seq_state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/ready_io_sequencer_if.sv
// ready_io_sequencer_if: start/done handshake and operand/result bus to the compute core
interface ready_io_sequencer_if import io_seq_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic start, busy, done;
  logic [WIDTH-1:0] x_out, y_out, x2_in, y2_in;
  modport master (output start, busy, x_out, y_out, input done, x2_in, y2_in);
  modport slave (input start, busy, x_out, y_out, output done, x2_in, y2_in);
endinterface

// File: rtl/ready_io_sequencer_ready_conditioner.sv
// ready_conditioner: synchronises ready, optionally debounces it (READY_DEBOUNCE_EN), emits rise/fall pulses
module ready_conditioner #(parameter int DEBOUNCE_CYCLES = 4) (
  input  logic clk,
  input  logic reset,
  input  logic ready,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic lvl, lvl_q;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
`ifdef READY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      lvl <= 1'b1;
    end else if (sync[1] == lvl) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      lvl <= sync[1];
    end else cnt <= cnt + 1'b1;
`else
  assign lvl = sync[1];
`endif
  // Reset to high so a ready already high at release is not seen as a rise
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync  <= 2'b11;
      lvl_q <= 1'b1;
    end else begin
      sync  <= {sync[0], ready};
      lvl_q <= lvl;
    end
  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;
endmodule

// File: rtl/ready_io_sequencer.sv
// ready_io_sequencer: operator I/O sequencing for the picoMIPS affine datapath
// Optional ready debounce filter enabled by defining READY_DEBOUNCE_EN.
module ready_io_sequencer import io_seq_pkg::*; #(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] LED,
  ready_io_sequencer_if.master dp
);
  seq_state_t state;
  logic rise, fall;
  logic [WIDTH-1:0] y2;
  ready_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
    .clk(clk), .reset(reset), .ready(ready), .rise(rise), .fall(fall)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= GET_X;
      LED      <= '0;
      y2       <= '0;
      dp.x_out <= '0;
      dp.y_out <= '0;
      dp.start <= 1'b0;
      dp.busy  <= 1'b0;
    end else begin
      dp.start <= 1'b0;
      case (state)
        GET_X: if (rise) begin
          dp.x_out <= sw;
          LED      <= sw;
          state    <= REL_X;
        end
        REL_X: if (fall) state <= GET_Y;
        GET_Y: if (rise) begin
          dp.y_out <= sw;
          LED      <= sw;
          state    <= REL_Y;
        end
        REL_Y: if (fall) begin
          dp.start <= 1'b1;
          dp.busy  <= 1'b1;
          state    <= COMPUTE;
        end
        COMPUTE: if (dp.done) begin
          y2      <= dp.y2_in;
          LED     <= dp.x2_in;
          dp.busy <= 1'b0;
          state   <= SHOW_X2;
        end
        SHOW_X2: if (rise) begin
          LED   <= y2;
          state <= SHOW_Y2;
        end
        SHOW_Y2: if (fall) state <= GET_X;
        default: state <= GET_X;
      endcase
    end
endmodule

// File: tb/tb_ready_io_sequencer.sv
// tb_ready_io_sequencer: scoreboard bench with a 3-cycle x+1/y+2 datapath model
module tb_ready_io_sequencer;
`ifdef READY_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0, reset = 1'b0, ready = 1'b1;
  logic [7:0] sw = '0, led;
  logic done_m = 1'b0;
  logic [7:0] x2_m = '0, y2_m = '0;
  int n_chk = 0, n_fail = 0, n_start = 0, cd = 0, dly = 3, inj_req = 0, inj_ack = 0, s0 = 0;
  logic [7:0] exp_q[$];
  ready_io_sequencer_if #(.WIDTH(8)) dp();
  ready_io_sequencer dut (.clk(clk), .reset(reset), .ready(ready), .sw(sw), .LED(led), .dp(dp));
  assign dp.done  = done_m;
  assign dp.x2_in = x2_m;
  assign dp.y2_in = y2_m;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    done_m = 1'b0;
    if (dp.start) begin
      n_start++;
      cd = dly;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        done_m = 1'b1;
        x2_m = dp.x_out + 8'd1;
        y2_m = dp.y_out + 8'd2;
      end
    end
    if (inj_req != inj_ack) begin
      done_m = 1'b1;
      inj_ack = inj_req;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] s, input logic [7:0] e, input string tag);
    sw = s;
    ready = v;
    exp_q.push_back(e);
    repeat (LAT) @(negedge clk);
    chk(tag, {24'd0, led}, {24'd0, exp_q.pop_front()});
  endtask
  task automatic wait_idle(input logic [7:0] e, input string tag);
    exp_q.push_back(e);
    for (int i = 0; i < 100 && dp.busy; i++) @(negedge clk);
    chk({tag, "_busy"}, {31'd0, dp.busy}, 32'd0);
    chk(tag, {24'd0, led}, {24'd0, exp_q.pop_front()});
  endtask
  initial begin
    repeat (10) @(negedge clk);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_start", {31'd0, dp.start}, 32'd0);
    chk("rst_busy", {31'd0, dp.busy}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_cap_led", {24'd0, led}, 32'd0);
    chk("no_cap_x", {24'd0, dp.x_out}, 32'd0);
    // run 1
    step(1'b0, 8'h00, 8'h00, "r1_low");
    step(1'b1, 8'h04, 8'h04, "r1_x");
    step(1'b0, 8'h08, 8'h04, "r1_rel");
    step(1'b1, 8'h08, 8'h08, "r1_y");
    chk("r1_xout", {24'd0, dp.x_out}, 32'h04);
    chk("r1_yout", {24'd0, dp.y_out}, 32'h08);
    s0 = n_start;
    step(1'b0, 8'h08, 8'h08, "r1_go");
    chk("r1_start", {31'd0, dp.start}, 32'd1);
    chk("r1_busy", {31'd0, dp.busy}, 32'd1);
    wait_idle(8'h05, "r1_x2");
    chk("r1_nstart", n_start - s0, 32'd1);
    step(1'b1, 8'h08, 8'h0A, "r1_y2");
    step(1'b0, 8'h08, 8'h0A, "r1_end");
    // run 2
    step(1'b1, 8'h05, 8'h05, "r2_x");
    step(1'b0, 8'h0A, 8'h05, "r2_rel");
    step(1'b1, 8'h0A, 8'h0A, "r2_y");
    step(1'b0, 8'h0A, 8'h0A, "r2_go");
    wait_idle(8'h06, "r2_x2");
    step(1'b1, 8'h0A, 8'h0C, "r2_y2");
    step(1'b0, 8'h0A, 8'h0C, "r2_end");
    // run 3: ready toggles during a long compute, then stray done in GET_X
    dly = 30;
    step(1'b1, 8'h11, 8'h11, "r3_x");
    step(1'b0, 8'h22, 8'h11, "r3_rel");
    step(1'b1, 8'h22, 8'h22, "r3_y");
    s0 = n_start;
    step(1'b0, 8'h22, 8'h22, "r3_go");
    step(1'b1, 8'h22, 8'h22, "r3_tog_hi");
    step(1'b0, 8'h22, 8'h22, "r3_tog_lo");
    chk("r3_busy_mid", {31'd0, dp.busy}, 32'd1);
    wait_idle(8'h12, "r3_x2");
    chk("r3_nstart", n_start - s0, 32'd1);
    step(1'b1, 8'h22, 8'h24, "r3_y2");
    step(1'b0, 8'h22, 8'h24, "r3_end");
    dly = 3;
    inj_req++;
    repeat (6) @(negedge clk);
    chk("stray_led", {24'd0, led}, 32'h24);
    chk("stray_busy", {31'd0, dp.busy}, 32'd0);
    chk("stray_nstart", n_start - s0, 32'd1);
    step(1'b1, 8'h31, 8'h31, "r4_x");
    chk("r4_xout", {24'd0, dp.x_out}, 32'h31);
    step(1'b0, 8'h32, 8'h31, "r4_rel");
    step(1'b1, 8'h32, 8'h32, "r4_y");
    step(1'b0, 8'h32, 8'h32, "r4_go");
    // reset one cycle before done arrives
    for (int i = 0; i < 40 && cd != 1; i++) @(posedge clk);
    chk("r4_cd_seen", cd, 32'd1);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_led", {24'd0, led}, 32'd0);
    chk("mid_rst_busy", {31'd0, dp.busy}, 32'd0);
    chk("mid_rst_x", {24'd0, dp.x_out}, 32'd0);
    chk("mid_rst_y", {24'd0, dp.y_out}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_led", {24'd0, led}, 32'd0);
    chk("post_rst_busy", {31'd0, dp.busy}, 32'd0);
`ifdef READY_DEBOUNCE_EN
    sw = 8'h77;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    ready = 1'b0;
    repeat (14) @(negedge clk);
    chk("glitch_led", {24'd0, led}, 32'd0);
    chk("glitch_x", {24'd0, dp.x_out}, 32'd0);
`endif
    step(1'b1, 8'h40, 8'h40, "r5_x");
    chk("r5_xout", {24'd0, dp.x_out}, 32'h40);
    step(1'b0, 8'h41, 8'h40, "r5_rel");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
